ntt_twiddle_sequencer: RTL
==========================

# ntt_twiddle_sequencer

Sequences reads from the single-port twiddle ROM for one NTT pass and presents the constants as a valid/ready stream to the butterfly datapath. It drives the ROM's `enable`/`address` pins and absorbs the ROM's one-cycle registered read latency in a small FIFO. Each twiddle is replayed a programmable number of times, once per butterfly that shares it. The block sits directly upstream of the ROM port and between it and the butterfly stage.

## Interface
- `MEM_WIDTH`, 16: twiddle word width; matches the ROM.
- `MEM_DEPTH`, 21: number of ROM entries. `AW = $clog2(MEM_DEPTH)` (5 at default).
- `REP_W`, 8: width of the repeat count.
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request pulse; sampled only in IDLE.
- `base_addr` in AW: first ROM address of the pass.
- `count` in AW+1: number of twiddles to fetch.
- `repeat_n` in REP_W: output beats per twiddle.
- `rom_enable` out 1: ROM read enable.
- `rom_address` out AW: ROM read address.
- `rom_dout` in MEM_WIDTH: ROM registered data; valid the cycle after `rom_enable`.
- `tw_data` out MEM_WIDTH: twiddle to the butterfly.
- `tw_valid` out 1: `tw_data` is valid.
- `tw_ready` in 1: consumer accepts the beat.
- `tw_last` out 1: final beat of the pass.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: one-cycle pulse after the last beat is accepted.
- `err` out 1: one-cycle pulse when a request is rejected.

## Operation
- **States:**
  - IDLE → RUN on a valid `start`.
  - RUN → DRAIN when all `count` reads have been issued.
  - DRAIN → IDLE when the last beat is accepted.
- **Request check:** a request is rejected when `count == 0`, `repeat_n == 0`, or `base_addr + count > MEM_DEPTH`. The sum is computed at AW+1 bits.
  - On rejection: `err` pulses the next cycle and the block stays in IDLE.
  - On acceptance: `base_addr`, `count` and `repeat_n` are latched; external changes afterwards have no effect.
- **`start` while busy:** ignored. No `err` is raised.
- **Read issue:** `rom_enable` = (state RUN) && (issued < count) && (fifo_occ + in_flight ≤ 2).
  - It is decoded from registered state only. There is no path from `tw_ready` to `rom_enable`.
  - `rom_address` = base + issued. It increments after each issued read. It does not wrap; the range check guarantees this.
- **Capture:** `in_flight` is `rom_enable` delayed one cycle. When `in_flight` = 1, `rom_dout` is pushed into a 4-entry FIFO. `rom_dout` is never sampled otherwise.
- **Output:**
  - `tw_valid` = FIFO not empty.
  - `tw_data` = FIFO head. It is held stable while `tw_valid && !tw_ready`.
  - A beat is accepted when `tw_valid && tw_ready`. Each accepted beat increments `rep_idx`.
  - When `rep_idx == repeat_n-1`, the head is popped, `rep_idx` returns to 0 and `popped` increments.
- **`tw_last`** = `tw_valid` && (`popped == count-1`) && (`rep_idx == repeat_n-1`).
- **Push and pop in the same cycle:** both take effect. Occupancy is unchanged.
- **FIFO overflow:** cannot occur by construction. The bench asserts it never happens.

## Timing
- **Reset values:** all outputs are 0. State = IDLE. The FIFO is emptied; occupancy, `in_flight` and all counters are 0.
- **Reset mid-pass:** the pass is aborted immediately; no `done` and no `err` are produced.
- **Start latency:** with `start` sampled at edge 0, `rom_enable` is first high in cycle 1 and `rom_dout` is captured at the end of cycle 2.
  - `tw_valid` rises in cycle 3.
  - `busy` rises in cycle 1.
- **Throughput:** with `tw_ready` held high and `repeat_n = 1`, the stream is one beat per cycle and has no bubbles after the first beat.
- **Completion:** `done` pulses in the cycle after the `tw_last` beat is accepted. `busy` falls in that same cycle.
- **Back-to-back passes:** a `start` coincident with the `done` pulse is accepted.
- **Backpressure:** with `tw_ready` low, at most 3 reads are outstanding plus buffered. After that, `rom_enable` stays low.

## Test plan
- **Basic pass:** reset, then start with base=0, count=3, repeat_n=1, `tw_ready`=1.
  - Required: `rom_address` 0,1,2 in cycles 1-3.
  - Required: `tw_data` follows the ROM contents in cycles 3-5 (0x1fdf, 0x1bff, 0x0aff with the current image).
  - Required: `tw_last` in cycle 5, `done` in cycle 6.
- **Repeat:** base=1, count=2, repeat_n=3.
  - Required: six beats, 0x1bff ×3 then 0x0aff ×3.
  - Required: `tw_last` only on beat 6.
- **Backpressure:** count=21, repeat_n=1, `tw_ready` random at 30%.
  - Required: all 21 words arrive in address order with no loss or duplication.
  - Required: `tw_data` is stable while stalled, and fifo_occ + in_flight never exceeds 3.
- **Rejection:**
  - base=20, count=2 → `err` pulse, no `rom_enable`, `busy` stays 0.
  - count=0 → `err`.
  - repeat_n=0 → `err`.
- **`start` while busy and back-to-back:**
  - A second `start` mid-pass is ignored.
  - A `start` coincident with `done` launches the next pass, with `rom_enable` the following cycle.
- **Reset mid-operation:** assert `reset_n` low during beat 5 of a count=10 pass.
  - Required: all outputs 0 asynchronously, no `done`.
  - Required: a fresh pass after reset starts from a clean state.

Source files
------------

// File: rtl/ntt_twiddle_sequencer.sv
// Twiddle ROM read sequencer for one NTT pass: issues ROM reads, absorbs the
// one-cycle read latency in a 4-entry FIFO and streams each twiddle repeat_n
// times to the butterfly datapath over valid/ready.
//
// Ports:
//   clock, reset_n          : rising-edge clock, async active-low reset
//   start                   : request pulse, sampled only when idle
//   base_addr/count/repeat_n: pass parameters, latched on an accepted start
//   rom_enable/rom_address  : ROM read port
//   rom_dout                : ROM registered data, valid one cycle after enable
//   tw_data/tw_valid/tw_last: twiddle stream to the butterfly
//   tw_ready                : consumer accepts the current beat
//   busy/done/err           : pass in progress / pass complete / request rejected
module ntt_twiddle_sequencer #(
    parameter int MEM_WIDTH = 16,
    parameter int MEM_DEPTH = 21,
    parameter int REP_W     = 8,
    localparam int AW       = $clog2(MEM_DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [AW-1:0]        base_addr,
    input  logic [AW:0]          count,
    input  logic [REP_W-1:0]     repeat_n,
    output logic                 rom_enable,
    output logic [AW-1:0]        rom_address,
    input  logic [MEM_WIDTH-1:0] rom_dout,
    output logic [MEM_WIDTH-1:0] tw_data,
    output logic                 tw_valid,
    input  logic                 tw_ready,
    output logic                 tw_last,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    localparam logic [AW:0]      CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]      DEPTH_C = (AW+1)'(MEM_DEPTH);
    localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

    state_t               r_state;
    logic [AW-1:0]        r_base;
    logic [AW:0]          r_count;
    logic [REP_W-1:0]     r_rep;
    logic [AW:0]          r_issued;
    logic [AW:0]          r_popped;
    logic [REP_W-1:0]     r_rep_idx;
    logic                 r_in_flight;
    logic [MEM_WIDTH-1:0] r_fifo [0:3];
    logic [1:0]           r_wr_ptr;
    logic [1:0]           r_rd_ptr;
    logic [2:0]           r_occ;
    logic                 r_done;
    logic                 r_err;

    logic [AW:0] w_sum;
    logic        w_reject;
    logic        w_rd_en;
    logic        w_valid;
    logic        w_accept;
    logic        w_rep_end;
    logic        w_pop;
    logic        w_last_tw;
    logic        w_final;

    assign w_sum    = {1'b0, base_addr} + count;
    assign w_reject = (count == '0) || (repeat_n == '0) || (w_sum > DEPTH_C);

    // Reads stop once buffered plus in-flight words reach 3, so the
    // 4-entry FIFO can never overflow; no dependence on tw_ready.
    assign w_rd_en = (r_state == S_RUN) && (r_issued < r_count) &&
                     ((r_occ + {2'b00, r_in_flight}) <= 3'd2);

    assign w_valid   = (r_occ != 3'd0);
    assign w_accept  = w_valid && tw_ready;
    assign w_rep_end = (r_rep_idx == r_rep - REP_ONE);
    assign w_pop     = w_accept && w_rep_end;
    assign w_last_tw = (r_popped == r_count - CNT_ONE);
    assign w_final   = w_pop && w_last_tw;

    assign rom_enable  = w_rd_en;
    assign rom_address = r_base + r_issued[AW-1:0];
    assign tw_valid    = w_valid;
    assign tw_data     = w_valid ? r_fifo[r_rd_ptr] : '0;
    assign tw_last     = w_valid && w_last_tw && w_rep_end;
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign err         = r_err;

    always_ff @(posedge clock) begin
        if (r_in_flight) begin
            r_fifo[r_wr_ptr] <= rom_dout;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (r_in_flight) r_wr_ptr <= r_wr_ptr + 2'd1;
            if (w_pop)       r_rd_ptr <= r_rd_ptr + 2'd1;
            unique case ({r_in_flight, w_pop})
                2'b10:   r_occ <= r_occ + 3'd1;
                2'b01:   r_occ <= r_occ - 3'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_count     <= '0;
            r_rep       <= '0;
            r_issued    <= '0;
            r_popped    <= '0;
            r_rep_idx   <= '0;
            r_in_flight <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_in_flight <= w_rd_en;
            if (w_rd_en) r_issued <= r_issued + CNT_ONE;
            if (w_accept) r_rep_idx <= w_rep_end ? '0 : r_rep_idx + REP_ONE;
            if (w_pop) r_popped <= r_popped + CNT_ONE;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_reject) begin
                            r_err <= 1'b1;
                        end else begin
                            r_base    <= base_addr;
                            r_count   <= count;
                            r_rep     <= repeat_n;
                            r_issued  <= '0;
                            r_popped  <= '0;
                            r_rep_idx <= '0;
                            r_state   <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_rd_en && (r_issued == r_count - CNT_ONE)) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_final) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
